// File: rtl/fp16_pkg.sv
// Shared binary16 constants and sequencer state encoding used by the int<->float
// conversion stages.
package fp16_pkg;

  localparam int F16_BIAS        = 15;
  localparam int F16_EXP_W       = 5;
  localparam int F16_MAN_W       = 10;
  localparam int F16_EXP_MAX_INT = 30;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    ABS,
    NORM,
    PACK,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

endpackage

// File: rtl/fp16_round_pack.sv
// Packs a normalized 16-bit magnitude into binary16. Rounding is either truncation
// or round-to-nearest-even.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic                 round_en,
  input  logic                 sign,
  input  logic [F16_EXP_W-1:0] exp,
  input  logic [15:0]          mag,
  output logic [15:0]          result
);

  logic [F16_MAN_W-1:0] mant;
  logic                 guard;
  logic                 sticky;
  logic                 inc;
  logic [F16_MAN_W:0]   mant_sum;
  logic [F16_EXP_W-1:0] exp_adj;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    mant     = mag[14:5];
    guard    = mag[4];
    sticky   = |mag[3:0];
    inc      = round_en & guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + {{F16_MAN_W{1'b0}}, inc};
    // A mantissa carry leaves the low bits at zero and bumps the exponent.
    exp_adj  = exp + {{(F16_EXP_W-1){1'b0}}, mant_sum[F16_MAN_W]};
    result   = '0;
    if (mag != '0) begin
      result = {sign, exp_adj, mant_sum[F16_MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/int2flt_seq.sv
// Sequential int16 -> binary16 converter. It reads the operand from data memory,
// normalizes it one shift per cycle, and writes the packed half-float back.
module int2flt_seq
  import fp16_pkg::*;
#(
  parameter logic [7:0] IN_ADDR  = 8'd0,
  parameter logic [7:0] OUT_ADDR = 8'd2,
  parameter logic       ROUND    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] dm_addr,
  output logic       dm_wr_en,
  output logic [7:0] dm_wdata,
  input  logic [7:0] dm_rdata
);

  state_t               state;
  state_t               state_next;
  logic                 start_q;
  logic [7:0]           lo;
  logic [7:0]           hi;
  logic                 sign;
  logic [15:0]          mag;
  logic [F16_EXP_W-1:0] exp;
  logic [15:0]          result;
  logic [15:0]          packed_val;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start;
    end
  end

  // NOTE: datapath registers carry no reset; each request reloads them before use.
  always_ff @(posedge clk) begin
    case (state)
      RD_LO: lo <= dm_rdata;
      RD_HI: hi <= dm_rdata;
      ABS: begin
        sign <= hi[7];
        mag  <= hi[7] ? (~{hi, lo} + 16'd1) : {hi, lo};
        exp  <= F16_EXP_W'(F16_EXP_MAX_INT);
      end
      NORM: begin
        if (!mag[15]) begin
          mag <= {mag[14:0], 1'b0};
          exp <= exp - 1'b1;
        end
      end
      PACK:    result <= packed_val;
      default: ;
    endcase
  end

  fp16_round_pack u_round_pack (
    .round_en (ROUND),
    .sign     (sign),
    .exp      (exp),
    .mag      (mag),
    .result   (packed_val)
  );

  always_comb begin
    state_next = state;
    done       = 1'b0;
    dm_wr_en   = 1'b0;
    dm_addr    = IN_ADDR;
    dm_wdata   = 8'h00;
    case (state)
      IDLE:  if (start_q && !start) state_next = RD_LO;
      RD_LO: state_next = RD_HI;
      RD_HI: begin
        dm_addr    = IN_ADDR + 8'd1;
        state_next = ABS;
      end
      // A zero operand skips normalization; the packer maps a zero magnitude to +0.
      ABS:   state_next = ({hi, lo} == 16'h0000) ? PACK : NORM;
      NORM:  if (mag[15]) state_next = PACK;
      PACK:  state_next = WR_LO;
      WR_LO: begin
        dm_wr_en   = 1'b1;
        dm_addr    = OUT_ADDR;
        dm_wdata   = result[7:0];
        state_next = WR_HI;
      end
      WR_HI: begin
        dm_wr_en   = 1'b1;
        dm_addr    = OUT_ADDR + 8'd1;
        dm_wdata   = result[15:8];
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_int2flt_seq.sv
// Directed bench for int2flt_seq: one truncating and one rounding instance, each
// with a small behavioural memory holding the operand at bytes 0/1.
module tb_int2flt_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start;
  logic [1:0] done;
  logic [1:0] wr_en;
  logic [7:0] addr  [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  logic [15:0] in_x [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] x, input logic [7:0] a);
    return (a == 8'd0) ? x[7:0] : (a == 8'd1) ? x[15:8] : 8'h00;
  endfunction

  assign rdata[0] = mem_rd(in_x[0], addr[0]);
  assign rdata[1] = mem_rd(in_x[1], addr[1]);

  int2flt_seq #(.IN_ADDR(8'd0), .OUT_ADDR(8'd2), .ROUND(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .done(done[0]), .dm_addr(addr[0]),
    .dm_wr_en(wr_en[0]), .dm_wdata(wdata[0]), .dm_rdata(rdata[0])
  );

  int2flt_seq #(.IN_ADDR(8'd0), .OUT_ADDR(8'd2), .ROUND(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .done(done[1]), .dm_addr(addr[1]),
    .dm_wr_en(wr_en[1]), .dm_wdata(wdata[1]), .dm_rdata(rdata[1])
  );

  task automatic do_reset();
    start = 2'b00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      if (done[r] !== 1'b0) begin
        n_fail++; $display("FAIL reset_done dut%0d: got %b expected 0", r, done[r]);
      end
      n_checks++;
      if (wr_en[r] !== 1'b0) begin
        n_fail++; $display("FAIL reset_wr_en dut%0d: got %b expected 0", r, wr_en[r]);
      end
      n_checks++;
      if (addr[r] !== 8'h00) begin
        n_fail++; $display("FAIL reset_addr dut%0d: got %h expected 00", r, addr[r]);
      end
      n_checks++;
      if (wdata[r] !== 8'h00) begin
        n_fail++; $display("FAIL reset_wdata dut%0d: got %h expected 00", r, wdata[r]);
      end
      n_checks++;
    end
  endtask

  // Launches one request, watches 40 cycles and checks result, latency and write pattern.
  // n counts cycles after the trigger cycle t0; toggle pulses start while the DUT is busy.
  task automatic run_op(input int r, input logic [15:0] x, input logic [15:0] exp_res,
                        input int exp_lat, input bit toggle, input string name);
    int done_n, done_cnt, wr_cnt, wr0_n, wr1_n;
    logic [7:0] wa [2];
    logic [7:0] wd [2];
    in_x[r] = x;
    @(negedge clk) start[r] = 1'b1;
    @(negedge clk) start[r] = 1'b0;
    done_n = -1; done_cnt = 0; wr_cnt = 0; wr0_n = -1; wr1_n = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done[r] === 1'b1) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (wr_en[r] === 1'b1) begin
        if (wr_cnt == 0) wr0_n = n;
        if (wr_cnt == 1) wr1_n = n;
        if (wr_cnt < 2) begin
          wa[wr_cnt] = addr[r];
          wd[wr_cnt] = wdata[r];
        end
        wr_cnt++;
      end
      if (toggle) begin
        if (n == 3 || n == 10) start[r] = 1'b1;
        if (n == 5 || n == 12) start[r] = 1'b0;
      end
    end
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    n_checks++;
    if (done_n !== exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, done_n, exp_lat);
    end
    n_checks++;
    if (wr_cnt !== 2) begin
      n_fail++; $display("FAIL %s write_count: got %0d expected 2", name, wr_cnt);
    end
    n_checks++;
    if (wr0_n !== exp_lat - 2 || wr1_n !== exp_lat - 1) begin
      n_fail++;
      $display("FAIL %s write_cycles: got %0d,%0d expected %0d,%0d", name, wr0_n, wr1_n,
               exp_lat - 2, exp_lat - 1);
    end
    n_checks++;
    if (wa[0] !== 8'd2 || wa[1] !== 8'd3) begin
      n_fail++; $display("FAIL %s write_addrs: got %h,%h expected 02,03", name, wa[0], wa[1]);
    end
    n_checks++;
    if ({wd[1], wd[0]} !== exp_res) begin
      n_fail++; $display("FAIL %s result: got %h expected %h", name, {wd[1], wd[0]}, exp_res);
    end
    n_checks++;
  endtask

  task automatic test_convert();
    run_op(0, 16'h0001, 16'h3C00, 23, 1'b0, "pos_one");
    run_op(0, 16'hFFFF, 16'hBC00, 23, 1'b0, "neg_one");
    run_op(0, 16'h0000, 16'h0000, 7,  1'b0, "zero");
    run_op(0, 16'h8000, 16'hF800, 8,  1'b0, "most_neg");
    run_op(0, 16'h7FFF, 16'h77FF, 9,  1'b0, "max_pos_trunc");
    run_op(0, 16'h0803, 16'h6801, 12, 1'b0, "trunc_0803");
  endtask

  task automatic test_round();
    run_op(1, 16'h7FFF, 16'h7800, 9,  1'b0, "max_pos_rne");
    run_op(1, 16'h0801, 16'h6800, 12, 1'b0, "tie_even_down");
    run_op(1, 16'h0803, 16'h6802, 12, 1'b0, "tie_odd_up");
    run_op(1, 16'h0001, 16'h3C00, 23, 1'b0, "rne_one");
  endtask

  task automatic test_reset_abort();
    int wr_seen, done_seen;
    wr_seen = 0; done_seen = 0;
    in_x[0] = 16'h0001;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (wr_en[0] === 1'b1) wr_seen++;
      if (done[0] === 1'b1) done_seen++;
      if (n == 6) reset = 1'b1;
      if (n == 7) reset = 1'b0;
    end
    if (wr_seen !== 0) begin
      n_fail++; $display("FAIL abort_writes: got %0d expected 0", wr_seen);
    end
    n_checks++;
    if (done_seen !== 0) begin
      n_fail++; $display("FAIL abort_done: got %0d expected 0", done_seen);
    end
    n_checks++;
    run_op(0, 16'h0001, 16'h3C00, 23, 1'b0, "after_abort");
  endtask

  task automatic test_busy_toggle();
    run_op(0, 16'h0001, 16'h3C00, 23, 1'b1, "busy_toggle");
    run_op(0, 16'hFFFF, 16'hBC00, 23, 1'b0, "back_to_back");
  endtask

  initial begin
    in_x[0] = 16'h0000;
    in_x[1] = 16'h0000;
    test_reset();
    test_convert();
    test_round();
    test_reset_abort();
    test_busy_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
